// File: rtl/jpeg_quant_stream.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_quant_stream
// Purpose  : Streaming JPEG coefficient quantizer. Each coefficient is scaled
//            by a per-position reciprocal (Q1.(RECIP_W-1)), rounded half away
//            from zero and saturated symmetrically. Two-stage pipeline with a
//            global stall; reciprocal table writes are only accepted while idle.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_quant_stream #(
  parameter  int DATA_W  = 12,
  parameter  int RECIP_W = 16,
  parameter  int BLOCK_N = 64,
  localparam int IDX_W   = $clog2(BLOCK_N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [RECIP_W-1:0] cfg_data,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);

  // Full-precision product width: signed coefficient times unsigned reciprocal.
  localparam int P_W = DATA_W + RECIP_W + 1;

  localparam logic [RECIP_W-1:0] c_UNITY = RECIP_W'(1) << (RECIP_W - 1);
  localparam logic [IDX_W-1:0]   c_LAST  = IDX_W'(BLOCK_N - 1);
  localparam logic [P_W:0]       c_HALF  = (P_W + 1)'(1) << (RECIP_W - 2);
  localparam logic [P_W:0]       c_MAXV  = (P_W + 1)'((1 << (DATA_W - 1)) - 1);

  logic [RECIP_W-1:0] r_table [BLOCK_N];
  logic [IDX_W-1:0]   r_in_idx;
  logic               r_cfg_err;

  logic               r_s1_valid;
  logic [DATA_W-1:0]  r_s1_data;
  logic [IDX_W-1:0]   r_s1_idx;
  logic [RECIP_W-1:0] r_s1_recip;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [IDX_W-1:0]   r_out_idx;
  logic               r_out_last;

  logic               w_advance;
  logic               w_in_xfer;
  logic               w_busy;
  logic signed [P_W-1:0] w_op_a;
  logic signed [P_W-1:0] w_op_b;
  logic signed [P_W-1:0] w_prod;
  logic               w_neg;
  logic [P_W-1:0]     w_abs;
  logic [P_W:0]       w_mag;
  logic [DATA_W-1:0]  w_sat;
  logic [DATA_W-1:0]  w_quant;

  // Global stall: everything moves together unless the output is blocked.
  assign w_advance = !r_out_valid || out_ready;
  assign w_in_xfer = in_valid && w_advance;
  assign w_busy    = (r_in_idx != '0) || r_s1_valid || r_out_valid;

  assign in_ready  = w_advance;
  assign busy      = w_busy;
  assign cfg_err   = r_cfg_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

  // Quantize the stage-1 coefficient: multiply, round magnitude, saturate, re-sign.
  always_comb begin
    w_op_a  = {{(RECIP_W + 1){r_s1_data[DATA_W-1]}}, r_s1_data};
    w_op_b  = {{DATA_W{1'b0}}, 1'b0, r_s1_recip};
    w_prod  = w_op_a * w_op_b;
    w_neg   = w_prod[P_W-1];
    w_abs   = w_neg ? P_W'(-w_prod) : P_W'(w_prod);
    w_mag   = ({1'b0, w_abs} + c_HALF) >> (RECIP_W - 1);
    w_sat   = (w_mag > c_MAXV) ? c_MAXV[DATA_W-1:0] : w_mag[DATA_W-1:0];
    w_quant = w_neg ? DATA_W'(-w_sat) : w_sat;
  end

  // Reciprocal table: writes land only while idle; a busy write raises cfg_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_N; i++) begin
        r_table[i] <= c_UNITY;
      end
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (cfg_we) begin
        if (w_busy) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_table[cfg_addr] <= cfg_data;
        end
      end
    end
  end

  // Position counter within the block, advancing on every accepted coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_idx <= '0;
    end else if (w_in_xfer) begin
      r_in_idx <= (r_in_idx == c_LAST) ? '0 : r_in_idx + IDX_W'(1);
    end
  end

  // Stage 1: capture coefficient, its index and the matching (pre-write) reciprocal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_idx   <= '0;
      r_s1_recip <= c_UNITY;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_data  <= in_data;
      r_s1_idx   <= r_in_idx;
      r_s1_recip <= r_table[r_in_idx];
    end
  end

  // Stage 2: register the quantized result, its index and the end-of-block flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_quant;
      r_out_idx   <= r_s1_idx;
      r_out_last  <= r_s1_valid && (r_s1_idx == c_LAST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quant_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_quant_stream
// Purpose  : Randomized and directed bench for jpeg_quant_stream against a
//            queue-based arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_quant_stream;

  localparam int DW = 12;
  localparam int RW = 16;
  localparam int N  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [RW-1:0] cfg_data;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  jpeg_quant_stream #(.DATA_W(DW), .RECIP_W(RW), .BLOCK_N(N)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    int cyc;
  } item_t;

  item_t         q[$];
  int            mtab[N];
  int            midx;
  int            cyc;
  int            n_in;
  int            checks;
  int            errors;
  bit            lat_mode;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_idx;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Arithmetic reference: round half away from zero, symmetric saturation.
  function automatic int ref_q(input int d, input int t);
    longint p, a, m;
    p = longint'(d) * longint'(t);
    a = (p < 0) ? -p : p;
    m = (a + (longint'(1) << (RW - 2))) / (longint'(1) << (RW - 1));
    if (m > (1 << (DW - 1)) - 1) m = (1 << (DW - 1)) - 1;
    return (p < 0) ? -int'(m) : int'(m);
  endfunction

  task automatic model_reset();
    q.delete();
    midx = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < N; i++) mtab[i] = 1 << (RW - 1);
  endtask

  // One clock cycle: drive at the falling edge, check, model the transfers.
  task automatic step(input bit v, input int d, input bit ordy,
                      input bit we = 1'b0, input int addr = 0, input int wd = 0);
    bit    mbusy, in_x, out_x, exp_err;
    item_t it;
    in_valid  = v;
    in_data   = d[DW-1:0];
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = addr[IW-1:0];
    cfg_data  = wd[RW-1:0];
    #1;
    mbusy = (midx != 0) || (q.size() != 0);
    check("busy", busy, mbusy);
    check("in_ready", in_ready, !out_valid || ordy);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_idx", out_idx, prev_idx);
    end
    out_x = out_valid && ordy;
    in_x  = v && in_ready;
    if (out_valid && q.size() == 0) begin
      check("spurious_out", out_valid, 0);
    end else if (out_x) begin
      it = q.pop_front();
      check("out_data", longint'($signed(out_data)), it.data);
      check("out_idx", out_idx, it.idx);
      check("out_last", out_last, it.idx == N - 1);
      if (lat_mode) check("latency", cyc - it.cyc, 2);
    end
    prev_stall = out_valid && !ordy;
    prev_data  = out_data;
    prev_idx   = out_idx;
    if (in_x) begin
      q.push_back('{ref_q(int'($signed(in_data)), mtab[midx]), midx, cyc});
      midx = (midx + 1) % N;
      n_in++;
    end
    exp_err = we && mbusy;
    if (we && !mbusy) mtab[addr] = wd;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("cfg_err", cfg_err, exp_err);
  endtask

  task automatic flush();
    for (int i = 0; i < 8 && q.size() != 0; i++) step(1'b0, 0, 1'b1);
    check("drained", q.size(), 0);
    step(1'b0, 0, 1'b1);
  endtask

  task automatic send_block(input int d0, input int d1);
    for (int i = 0; i < N; i++) begin
      if (i == 0)      step(1'b1, d0, 1'b1);
      else if (i == 1) step(1'b1, d1, 1'b1);
      else             step(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; n_in = 0; lat_mode = 1'b1;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);

    // Pass-through ramp 0..63.
    for (int i = 0; i < N; i++) step(1'b1, i, 1'b1);
    flush();

    // Rounding and saturation entries, then three blocks.
    step(1'b0, 0, 1'b1, 1'b1, 0, 2048);
    step(1'b0, 0, 1'b1, 1'b1, 1, 16'hFFFF);
    send_block(100, 2047);
    send_block(24, -2048);
    send_block(-100, 0);
    flush();

    // Write while busy is rejected, accepted after the block ends.
    for (int i = 0; i < 10; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    step(1'b1, 1000, 1'b1, 1'b1, 5, 1234);
    for (int i = 11; i < N; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    flush();
    step(1'b0, 0, 1'b1, 1'b1, 5, 1234);
    // Write coincident with the first coefficient: index 0 uses the old entry.
    step(1'b1, 500, 1'b1, 1'b1, 0, 8192);
    for (int i = 1; i < N; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    flush();

    // Randomized backpressure over three blocks.
    lat_mode = 1'b0;
    n_in = 0;
    for (int c = 0; c < 3000 && n_in < 3 * N; c++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 4095)), ($urandom % 2) != 0,
           ($urandom % 16) == 0, int'($urandom_range(0, N - 1)),
           int'($urandom_range(16384, 65535)));
    end
    check("random_inputs", n_in, 3 * N);
    flush();

    // Reset mid-block with data in flight.
    lat_mode = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    check("inflight", q.size(), 2);
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jpeg_quant_stream.md
JPEG_QUANT_STREAM -- requirements
Module: jpeg_quant_stream

Interface
REQ-001 Parameter DATA_W, default 12, coefficient width: signed two's complement, input and output.
REQ-002 Parameter RECIP_W, default 16, reciprocal table entry width: unsigned Q1.(RECIP_W-1), unity = 2^(RECIP_W-1).
REQ-003 Parameter BLOCK_N, default 64, coefficients per block; index width IDX_W = clog2(BLOCK_N).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_we  input  1  table write strobe.
REQ-007 cfg_addr  input  IDX_W  table entry index.
REQ-008 cfg_data  input  RECIP_W  reciprocal value to write.
REQ-009 cfg_err  output  1  one-cycle pulse: write rejected because the block is busy.
REQ-010 in_valid  input  1  in_data holds a coefficient.
REQ-011 in_ready  output  1  block accepts a coefficient this cycle.
REQ-012 in_data  input  DATA_W  DCT coefficient, natural order within the block.
REQ-013 out_valid  output  1  out_data holds a quantized coefficient.
REQ-014 out_ready  input  1  sink accepts the output this cycle.
REQ-015 out_data  output  DATA_W  quantized coefficient.
REQ-016 out_idx  output  IDX_W  position of out_data within its block.
REQ-017 out_last  output  1  high with out_valid when out_idx = BLOCK_N-1.
REQ-018 busy  output  1  high when in_idx != 0 or any pipeline stage is valid.

Function
REQ-019 An input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-020 The block is a 2-stage pipeline with global stall: advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-021 Stage 1 SHALL register the coefficient, the current in_idx, and table[in_idx]; stage 2 SHALL register the quantized result, the index, and out_last.
REQ-022 Latency SHALL be 2 cycles from input transfer to out_valid when out_ready is held high; sustained throughput SHALL be 1 coefficient per cycle.
REQ-023 While stalled (advance=0), all stage registers and out_* SHALL hold their values.
REQ-024 in_idx SHALL increment on each input transfer and wrap from BLOCK_N-1 to 0.
REQ-025 Quantization: p = in_data * table entry (signed x unsigned, DATA_W+RECIP_W+1 bits); m = (|p| + 2^(RECIP_W-2)) >> (RECIP_W-1); result = sign(p) * m (round half away from zero).
REQ-026 The result SHALL saturate symmetrically to [-(2^(DATA_W-1)-1), +(2^(DATA_W-1)-1)].
REQ-027 A table write SHALL be accepted only when busy=0; the write SHALL update the entry on that edge and cfg_err SHALL stay low.
REQ-028 A table write attempted while busy=1 SHALL leave the table unchanged and pulse cfg_err high for exactly one cycle.
REQ-029 When cfg_we coincides with an input transfer and busy=0, the write SHALL take effect, and the coefficient at index 0 SHALL use the old entry.

Reset
REQ-030 On rst: in_idx=0, stage valids=0, out_valid=0, out_data=0, out_idx=0, out_last=0, cfg_err=0, busy=0, and every table entry = 2^(RECIP_W-1) (pass-through).
REQ-031 in_ready SHALL be 1 while rst is high and after reset; a reset mid-block SHALL discard in-flight data, and the next accepted coefficient SHALL be index 0.

Verification
REQ-032 Reset table, stream 64 values 0..63 with out_ready=1 -> outputs equal inputs 2 cycles later; out_last only on index 63; busy=0 afterwards.
REQ-033 Load table[0]=2048 (Q=16), send block with in_data[0]=100, then 24, then -100 in successive blocks at index 0 -> out_data 6, 2, -6 respectively.
REQ-034 table[1]=0xFFFF, in_data[1]=2047 -> 2047; in_data[1]=-2048 -> -2047 (saturation).
REQ-035 Randomised out_ready 50% over 3 blocks -> no lost or duplicated coefficients; out_idx sequence 0..63 repeated; outputs stable while stalled.
REQ-036 cfg_we at in_idx=10 -> cfg_err pulse for 1 cycle and entry unchanged; same write after block end -> accepted.
REQ-037 Assert rst at in_idx=30 with 2 coefficients in flight -> out_valid=0 next cycle; the following block begins at out_idx=0 with pass-through table.
